ma_ext: RTL and testbench

Parametrised memory-access (MA) stage for the MIPS core. It adds byte/halfword loads and stores with sign/zero extension, alignment checking, and a configurable data-memory latency with a stall handshake. It sits between execute and write-back and produces the registered write-back value `Wdata`.

---
 rtl/ma_ext_pkg.sv | 50 +++++
 rtl/ma_dmem.sv | 39 +++
 rtl/ma_ext.sv | 203 ++++++++++++++++++++
 tb/tb_ma_ext.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ma_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ma_ext_pkg
// Purpose : Shared opcode constants, FSM state encoding and small decode
//           helpers for the memory-access stage (ma_ext / ma_dmem).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ma_ext_pkg;

  localparam int c_DMEM_SIZE = 1024;

  localparam logic [5:0] c_OP_JAL = 6'h03;
  localparam logic [5:0] c_OP_LB  = 6'h20;
  localparam logic [5:0] c_OP_LH  = 6'h21;
  localparam logic [5:0] c_OP_LW  = 6'h23;
  localparam logic [5:0] c_OP_LBU = 6'h24;
  localparam logic [5:0] c_OP_LHU = 6'h25;
  localparam logic [5:0] c_OP_SB  = 6'h28;
  localparam logic [5:0] c_OP_SH  = 6'h29;
  localparam logic [5:0] c_OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic f_is_load(input logic [5:0] op);
    return (op == c_OP_LB) || (op == c_OP_LH) || (op == c_OP_LW) ||
           (op == c_OP_LBU) || (op == c_OP_LHU);
  endfunction

  function automatic logic f_is_store(input logic [5:0] op);
    return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
  endfunction

  // Halfword ops need an even address, word ops a word-aligned address.
  function automatic logic f_misaligned(input logic [5:0] op, input logic [1:0] lane);
    logic r;
    case (op)
      c_OP_LH, c_OP_LHU, c_OP_SH: r = lane[0];
      c_OP_LW, c_OP_SW:           r = (lane != 2'b00);
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ma_dmem.sv
`default_nettype none
// ============================================================================
// Module  : ma_dmem
// Purpose : WORDS x 32 data memory, synchronous byte-enabled write,
//           combinational read. Contents are intentionally not reset.
// Ports   : clk      - clock
//           i_we     - write strobe
//           i_be     - per-byte write enables (bit 0 = bits [7:0])
//           i_addr   - word index
//           i_wdata  - write data (lanes selected by i_be)
//           o_rdata  - read data of word i_addr
// Revision: 1.0 - initial release
// ============================================================================
module ma_dmem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/ma_ext.sv
`default_nettype none
// ============================================================================
// Module  : ma_ext
// Purpose : MIPS memory-access stage. Byte/halfword/word loads and stores
//           with sign/zero extension, alignment checking, configurable
//           memory latency (LAT wait cycles) and a stall handshake.
// Ports   : CLK, RST            - clock, async active-high reset
//           in_valid            - instruction presented (accepted if !stall)
//           Ins/Result/Rdata2   - instruction, ALU result/address, rt value
//           nextPC              - PC+4 for JAL
//           stall               - stage busy (wait states in progress)
//           out_valid           - one-cycle pulse, Wdata/adr_err valid
//           Wdata               - registered write-back value
//           adr_err             - misaligned access flag
// Revision: 1.0 - initial release
// ============================================================================
module ma_ext
  import ma_ext_pkg::*;
#(
  parameter int DMEM_WORDS = c_DMEM_SIZE,
  parameter int LAT        = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  input  logic [31:0] nextPC,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] Wdata,
  output logic        adr_err
);

  localparam int         AW         = $clog2(DMEM_WORDS);
  localparam bit         c_HAS_WAIT = (LAT > 0);
  localparam logic [3:0] c_LAT_M1   = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_ins, r_res, r_rd2, r_npc;
  logic [31:0] r_wdata;
  logic        r_adr_err;

  logic        w_in_wait, w_accept, w_complete;
  logic [31:0] w_ins, w_res, w_rd2, w_npc;
  logic [5:0]  w_op;
  logic [1:0]  w_lane;
  logic        w_is_ld, w_is_st, w_misal, w_mem_ok;
  logic [31:0] w_rd_word, w_st_data, w_wdata_nxt;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_we;
  logic        w_unused_bits;

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_accept  = in_valid && !w_in_wait;

  // Ops that complete on their accept edge use the live inputs; ops that
  // finish after wait states use the copy captured at acceptance.
  assign w_ins = w_in_wait ? r_ins : Ins;
  assign w_res = w_in_wait ? r_res : Result;
  assign w_rd2 = w_in_wait ? r_rd2 : Rdata2;
  assign w_npc = w_in_wait ? r_npc : nextPC;

  assign w_op     = w_ins[31:26];
  assign w_lane   = w_res[1:0];
  assign w_is_ld  = f_is_load(w_op);
  assign w_is_st  = f_is_store(w_op);
  assign w_misal  = f_misaligned(w_op, w_lane);
  assign w_mem_ok = (w_is_ld || w_is_st) && !w_misal;

  assign w_unused_bits = ^{w_ins[25:0], w_res[31:AW+2]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_complete  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        // IDLE and RESP both accept, which gives back-to-back issue.
        if (w_accept) begin
          if (w_mem_ok && c_HAS_WAIT) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_LAT_M1;
          end else begin
            w_state_nxt = ST_RESP;
            w_complete  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // ------------------------------------------------------ input capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ins <= '0;
      r_res <= '0;
      r_rd2 <= '0;
      r_npc <= '0;
    end else if (w_accept) begin
      r_ins <= Ins;
      r_res <= Result;
      r_rd2 <= Rdata2;
      r_npc <= nextPC;
    end
  end

  // ------------------------------------------------------- data memory
  always_comb begin
    w_be      = 4'b0000;
    w_st_data = w_rd2;
    case (w_op)
      c_OP_SB: begin
        w_be      = 4'b0001 << w_lane;
        w_st_data = {4{w_rd2[7:0]}};
      end
      c_OP_SH: begin
        w_be      = 4'b0011 << w_lane;
        w_st_data = {2{w_rd2[15:0]}};
      end
      c_OP_SW: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_we = w_complete && w_is_st && !w_misal;

  ma_dmem #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_dmem (
    .clk     (CLK),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_res[AW+1:2]),
    .i_wdata (w_st_data),
    .o_rdata (w_rd_word)
  );

  // ------------------------------------------- lane select and extend
  assign w_byte = w_rd_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_wdata_nxt = w_res;
    if (w_misal) begin
      w_wdata_nxt = 32'd0;
    end else begin
      case (w_op)
        c_OP_LB:                   w_wdata_nxt = {{24{w_byte[7]}}, w_byte};
        c_OP_LBU:                  w_wdata_nxt = {24'd0, w_byte};
        c_OP_LH:                   w_wdata_nxt = {{16{w_half[15]}}, w_half};
        c_OP_LHU:                  w_wdata_nxt = {16'd0, w_half};
        c_OP_LW:                   w_wdata_nxt = w_rd_word;
        c_OP_SB, c_OP_SH, c_OP_SW: w_wdata_nxt = w_rd2;
        c_OP_JAL:                  w_wdata_nxt = w_npc;
        default:                   w_wdata_nxt = w_res;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wdata   <= 32'd0;
      r_adr_err <= 1'b0;
    end else if (w_complete) begin
      r_wdata   <= w_wdata_nxt;
      r_adr_err <= w_misal;
    end
  end

  assign stall     = w_in_wait;
  assign out_valid = (r_state == ST_RESP);
  assign Wdata     = r_wdata;
  assign adr_err   = r_adr_err;

endmodule
`default_nettype wire

// File: tb/tb_ma_ext.sv
`default_nettype none
// ============================================================================
// Module  : tb_ma_ext
// Purpose : Directed self-checking bench for ma_ext (LAT=2, DMEM_WORDS=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ma_ext;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [31:0] Ins, Result, Rdata2, nextPC;
  logic        stall, out_valid, adr_err;
  logic [31:0] Wdata;

  int n_cmp = 0;
  int n_mis = 0;

  ma_ext #(.DMEM_WORDS(16), .LAT(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .Ins       (Ins),
    .Result    (Result),
    .Rdata2    (Rdata2),
    .nextPC    (nextPC),
    .stall     (stall),
    .out_valid (out_valid),
    .Wdata     (Wdata),
    .adr_err   (adr_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, then track latency, stall cycles and the result pulse.
  task automatic run_op(input string tag, input logic [5:0] op,
                        input logic [31:0] res, input logic [31:0] rd2,
                        input logic [31:0] npc, input logic [31:0] exp_wd,
                        input logic exp_err, input int exp_lat);
    int  lat;
    int  nst;
    bit  seen;
    @(negedge CLK);
    Ins = {op, 26'h2AAAAAA}; Result = res; Rdata2 = rd2; nextPC = npc;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    Ins = 32'hFFFF_FFFF; Result = 32'hA5A5_A5A5; Rdata2 = 32'h5A5A_5A5A; nextPC = 32'h0;
    lat = 0; nst = 0; seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge CLK);
      if (out_valid) begin
        seen = 1'b1;
        lat  = k;
      end else if (stall) begin
        nst++;
      end
    end
    chk({tag, "/latency"}, lat, exp_lat);
    chk({tag, "/stall_cycles"}, nst, exp_lat - 1);
    chk({tag, "/Wdata"}, Wdata, exp_wd);
    chk({tag, "/adr_err"}, {31'd0, adr_err}, {31'd0, exp_err});
    @(negedge CLK);
    chk({tag, "/pulse_end"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "/Wdata_hold"}, Wdata, exp_wd);
  endtask

  // Back-to-back stream tables (index = negedge number from first present).
  logic [5:0]  s_op  [4] = '{6'h23, 6'h00, 6'h2B, 6'h23};
  logic [31:0] s_res [4] = '{32'h20, 32'h77, 32'h20, 32'h20};
  logic [31:0] s_rd2 [4] = '{32'h0, 32'h0, 32'h2468ACE0, 32'h0};
  logic [11:0] s_stall = 12'b0011_0110_0110; // bit n = negedge n
  logic [11:0] s_ov    = 12'b0100_1001_1000;
  logic [31:0] s_wd    [4] = '{32'h13579BDF, 32'h77, 32'h2468ACE0, 32'h2468ACE0};

  initial begin
    int idx;
    int nwd;
    bit acc;
    RST = 1'b1; in_valid = 1'b0;
    Ins = '0; Result = '0; Rdata2 = '0; nextPC = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset/stall", {31'd0, stall}, 32'd0);
    chk("reset/out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset/Wdata", Wdata, 32'd0);
    chk("reset/adr_err", {31'd0, adr_err}, 32'd0);
    RST = 1'b0;

    run_op("add",       6'h00, 32'h1234, 32'h0, 32'h0, 32'h1234, 1'b0, 1);
    run_op("sw80",      6'h2B, 32'h80, 32'h11223344, 32'h0, 32'h11223344, 1'b0, 3);
    run_op("sb81",      6'h28, 32'h81, 32'h123456AA, 32'h0, 32'h123456AA, 1'b0, 3);
    run_op("lw80",      6'h23, 32'h80, 32'h0, 32'h0, 32'h1122AA44, 1'b0, 3);
    run_op("lb81",      6'h20, 32'h81, 32'h0, 32'h0, 32'hFFFFFFAA, 1'b0, 3);
    run_op("lbu81",     6'h24, 32'h81, 32'h0, 32'h0, 32'h000000AA, 1'b0, 3);
    run_op("sw84",      6'h2B, 32'h84, 32'h77665544, 32'h0, 32'h77665544, 1'b0, 3);
    run_op("sh86",      6'h29, 32'h86, 32'hCAFE8001, 32'h0, 32'hCAFE8001, 1'b0, 3);
    run_op("lh86",      6'h21, 32'h86, 32'h0, 32'h0, 32'hFFFF8001, 1'b0, 3);
    run_op("lhu86",     6'h25, 32'h86, 32'h0, 32'h0, 32'h00008001, 1'b0, 3);
    run_op("lw84",      6'h23, 32'h84, 32'h0, 32'h0, 32'h80015544, 1'b0, 3);
    run_op("lh85_mis",  6'h21, 32'h85, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    run_op("sw82_mis",  6'h2B, 32'h82, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1);
    run_op("sh87_mis",  6'h29, 32'h87, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1);
    run_op("lw80_keep", 6'h23, 32'h80, 32'h0, 32'h0, 32'h1122AA44, 1'b0, 3);
    run_op("lw84_keep", 6'h23, 32'h84, 32'h0, 32'h0, 32'h80015544, 1'b0, 3);
    run_op("sw40_wrap", 6'h2B, 32'h40, 32'hCAFEBABE, 32'h0, 32'hCAFEBABE, 1'b0, 3);
    run_op("lw0_wrap",  6'h23, 32'h0, 32'h0, 32'h0, 32'hCAFEBABE, 1'b0, 3);
    run_op("jal",       6'h03, 32'h99, 32'h0, 32'h400008, 32'h00400008, 1'b0, 1);

    // Reset abort: old contents first, then a store killed mid-wait.
    run_op("sw10_old",  6'h2B, 32'h10, 32'h0BADF00D, 32'h0, 32'h0BADF00D, 1'b0, 3);
    @(negedge CLK);
    Ins = {6'h2B, 26'h0}; Result = 32'h10; Rdata2 = 32'hDEADBEEF; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort/stall_before", {31'd0, stall}, 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("abort/stall_async", {31'd0, stall}, 32'd0);
    chk("abort/out_valid_async", {31'd0, out_valid}, 32'd0);
    chk("abort/Wdata_async", Wdata, 32'd0);
    chk("abort/adr_err_async", {31'd0, adr_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    nwd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (out_valid) nwd++;
    end
    chk("abort/no_out_valid", nwd, 32'd0);
    run_op("lw10_old",  6'h23, 32'h10, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 3);
    run_op("add_post",  6'h00, 32'h1234, 32'h0, 32'h0, 32'h1234, 1'b0, 1);

    // Back-to-back stream LW, ADD, SW, LW with in_valid held high.
    run_op("sw20_init", 6'h2B, 32'h20, 32'h13579BDF, 32'h0, 32'h13579BDF, 1'b0, 3);
    idx = 0; nwd = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      chk($sformatf("b2b/stall_%0d", n), {31'd0, stall}, {31'd0, s_stall[n]});
      chk($sformatf("b2b/out_valid_%0d", n), {31'd0, out_valid}, {31'd0, s_ov[n]});
      if (out_valid && nwd < 4) begin
        chk($sformatf("b2b/Wdata_%0d", nwd), Wdata, s_wd[nwd]);
        nwd++;
      end
      if (idx < 4) begin
        Ins = {s_op[idx], 26'h0}; Result = s_res[idx]; Rdata2 = s_rd2[idx];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && !stall;
      @(posedge CLK); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("b2b/results_seen", nwd, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
